// File: rtl/keypad_scanner.sv
// Column scanner for a 4-row keypad matrix. It gates the row edge detector and turns
// new key presses into one-cycle key_valid/key_code events, reporting each held key once.
module keypad_scanner #(
    parameter int NUM_COLS     = 4,
    parameter int DWELL_CYCLES = 8,
    parameter int CODE_W       = $clog2(NUM_COLS * 4)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                scan_en,
    input  logic [3:0]          row_edge,
    input  logic [3:0]          row_raw,
    output logic [NUM_COLS-1:0] col_drive,
    output logic                dbnc_en,
    output logic                key_valid,
    output logic [CODE_W-1:0]   key_code
);

    localparam int COL_W = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
    localparam int CNT_W = $clog2(DWELL_CYCLES);
    localparam logic [COL_W-1:0] LAST_COL   = COL_W'(NUM_COLS - 1);
    localparam logic [CNT_W-1:0] LAST_DWELL = CNT_W'(DWELL_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        FLUSH,
        DWELL
    } state_t;

    state_t                state;
    logic [COL_W-1:0]      col_idx;
    logic [CNT_W-1:0]      dwell_cnt;
    logic [3:0]            pending;
    logic [NUM_COLS*4-1:0] key_state;

    logic [3:0]            held;
    logic [3:0]            cand;
    logic [3:0]            pick;
    logic [1:0]            pick_row;
    logic [COL_W-1:0]      col_next;
    logic [CODE_W-1:0]     pick_code;

    // NOTE: every signal gets a default at the top of always_comb so no path leaves it
    // unassigned; an unassigned path would infer a latch.
    always_comb begin
        held     = key_state[col_idx*4 +: 4];
        cand     = pending | (row_edge & ~held);
        pick_row = 2'd0;
        for (int r = 3; r >= 0; r--) begin
            if (cand[r]) pick_row = 2'(r);
        end
        pick      = 4'b0001 << pick_row;
        col_next  = (col_idx == LAST_COL) ? '0 : col_idx + 1'b1;
        pick_code = (CODE_W'(col_idx) << 2) | CODE_W'(pick_row);
    end

    // NOTE: state registers use non-blocking assignments so every branch reads the values
    // from before the edge, matching the flop hardware regardless of statement order.
    // NOTE: key_state is a small flag vector, not a RAM, so it is cleared by reset like the
    // other registers; a stale held-bit would silently suppress the first press after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            col_idx   <= '0;
            col_drive <= '0;
            dbnc_en   <= 1'b0;
            key_valid <= 1'b0;
            key_code  <= '0;
            pending   <= '0;
            key_state <= '0;
            dwell_cnt <= '0;
        end else if (!scan_en) begin
            // Held-key flags and column survive a pause so scanning resumes where it left off.
            state     <= IDLE;
            col_drive <= '0;
            dbnc_en   <= 1'b0;
            pending   <= '0;
            key_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state     <= FLUSH;
                    col_drive <= NUM_COLS'(1) << col_idx;
                    dbnc_en   <= 1'b0;
                    key_valid <= 1'b0;
                end
                FLUSH: begin
                    state     <= DWELL;
                    dwell_cnt <= '0;
                    dbnc_en   <= 1'b1;
                    key_valid <= 1'b0;
                end
                DWELL: begin
                    dwell_cnt <= dwell_cnt + 1'b1;
                    if (dwell_cnt == LAST_DWELL) begin
                        // Only releases are learned here; presses must come through an edge.
                        key_state[col_idx*4 +: 4] <= held & row_raw;
                        pending   <= '0;
                        key_valid <= 1'b0;
                        col_idx   <= col_next;
                        col_drive <= NUM_COLS'(1) << col_next;
                        dbnc_en   <= 1'b0;
                        state     <= FLUSH;
                    end else if (cand != 4'd0) begin
                        key_valid <= 1'b1;
                        key_code  <= pick_code;
                        key_state[col_idx*4 + int'(pick_row)] <= 1'b1;
                        pending   <= cand & ~pick;
                    end else begin
                        key_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a keypad plus 3-stage row edge detector model drives the DUT,
// stimulus pushes expected key codes into a queue and a monitor pops them on key_valid.
module tb_keypad_scanner;

    logic       clk = 1'b0;
    logic       rst;
    logic       scan_en;
    logic [3:0] row_edge;
    logic [3:0] row_raw;
    logic [3:0] col_drive;
    logic       dbnc_en;
    logic       key_valid;
    logic [3:0] key_code;

    keypad_scanner #(
        .NUM_COLS    (4),
        .DWELL_CYCLES(8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .scan_en  (scan_en),
        .row_edge (row_edge),
        .row_raw  (row_raw),
        .col_drive(col_drive),
        .dbnc_en  (dbnc_en),
        .key_valid(key_valid),
        .key_code (key_code)
    );

    always #5 clk = ~clk;

    // Keypad matrix (index col*4+row) and the edge detector pipeline behind the rows.
    logic [15:0] keys;
    logic [3:0]  man_edge;
    logic [3:0]  s1 = '0;
    logic [3:0]  s2 = '0;
    logic [3:0]  s3 = '0;
    logic [3:0]  last_edge = '0;

    assign row_raw  = s2;
    assign row_edge = (s2 & ~s3) | man_edge;

    function automatic logic [3:0] cur_rows(input logic [3:0] cols, input logic [15:0] k);
        logic [3:0] rows;
        rows = '0;
        for (int c = 0; c < 4; c++) begin
            if (cols[c]) rows = rows | k[c*4 +: 4];
        end
        return rows;
    endfunction

    always @(posedge clk) begin
        #2;
        if (!dbnc_en) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
        end else begin
            s3 <= s2;
            s2 <= s1;
            s1 <= cur_rows(col_drive, keys);
        end
    end

    always @(posedge clk) last_edge <= row_edge;

    typedef struct {
        logic [3:0] code;
        bit         chk_edge;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [3:0] code, input bit chk_edge);
        exp_t e;
        e.code     = code;
        e.chk_edge = chk_edge;
        exp_q.push_back(e);
    endtask

    // Waits for the FLUSH cycle of column col, then d more cycles (d=1 is the first dwell cycle).
    task automatic wait_col(input int col, input int d);
        int         n;
        logic [3:0] oh;
        n  = 0;
        oh = 4'b0001 << col;
        @(negedge clk);
        while (!(col_drive == oh && dbnc_en == 1'b0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("sync_col%0d", col), 32'(n < 200), 32'd1);
        repeat (d) @(negedge clk);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && key_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_key_valid: got code %0d, want no pulse at %0t",
                         key_code, $time);
            end else begin
                e = exp_q.pop_front();
                check("key_code", 32'(key_code), 32'(e.code));
                if (e.chk_edge) check("edge_latency", 32'(last_edge[e.code[1:0]]), 32'd1);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] oh;
        rst      = 1'b1;
        scan_en  = 1'b0;
        keys     = '0;
        man_edge = '0;
        repeat (3) @(negedge clk);
        check("reset_col_drive", 32'(col_drive), 32'd0);
        check("reset_dbnc_en",   32'(dbnc_en),   32'd0);
        check("reset_key_valid", 32'(key_valid), 32'd0);
        check("reset_key_code",  32'(key_code),  32'd0);

        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_col_drive", 32'({col_drive, dbnc_en}), 32'd0);

        // Column sequence with wrap: 9 cycles per column, detector off on the first one.
        scan_en = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 45; i++) begin
            oh = 4'b0001 << ((i / 9) % 4);
            check($sformatf("col_seq_%0d", i), 32'({col_drive, dbnc_en}),
                  32'({oh, (i % 9) != 0}));
            @(negedge clk);
        end

        // Key col2/row1 held over many scans: one report, then again after release and re-press.
        wait_col(0, 0);
        keys[9] = 1'b1;
        push(4'd9, 1'b1);
        repeat (5 * 36) @(negedge clk);
        wait_col(0, 0);
        keys[9] = 1'b0;
        wait_col(0, 0);
        keys[9] = 1'b1;
        push(4'd9, 1'b1);
        wait_col(0, 0);
        keys[9] = 1'b0;

        // Two simultaneous edges in column 0: reported lowest row first on consecutive cycles.
        wait_col(0, 3);
        man_edge = 4'b1001;
        push(4'd0, 1'b1);
        push(4'd3, 1'b0);
        @(negedge clk);
        man_edge = 4'b0000;
        repeat (3) @(negedge clk);
        check("post_burst_key_valid", 32'(key_valid), 32'd0);
        check("key_code_holds",       32'(key_code),  32'd3);

        // Edge on the last dwell cycle of column 3 is ignored; the held key reports next visit.
        wait_col(3, 8);
        man_edge  = 4'b0100;
        keys[14]  = 1'b1;
        push(4'd14, 1'b1);
        @(negedge clk);
        man_edge = 4'b0000;
        wait_col(3, 5);
        keys[14] = 1'b0;

        // Pausing the scan blanks the outputs on the next cycle.
        wait_col(2, 4);
        scan_en = 1'b0;
        @(negedge clk);
        check("pause_outputs", 32'({col_drive, dbnc_en, key_valid}), 32'd0);
        scan_en = 1'b1;

        // Reset mid-dwell with pending rows: outputs clear at once, scan restarts at column 0.
        wait_col(1, 3);
        man_edge = 4'b1111;
        push(4'd4, 1'b1);
        @(negedge clk);
        man_edge = 4'b0000;
        #1 rst = 1'b1;
        #1;
        check("rst_outputs", 32'({col_drive, dbnc_en, key_valid, key_code}), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("restart_first_col", 32'({col_drive, dbnc_en}), 32'({4'b0001, 1'b0}));

        repeat (40) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
